// File: rtl/adc_freq_meas_pkg.sv
// Shared definitions for the ADC frequency / amplitude meter.
// FSM encoding, mid-scale derivation and default tuning constants.
package adc_freq_meas_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_MEAS,
        ST_DONE
    } meas_state_e;

    localparam int DEF_HYST    = 64;
    localparam int DEF_TIMEOUT = 1 << 24;

    // Offset-binary mid-scale code for a given sample width
    function automatic int mid_code(input int w);
        return 1 << (w - 1);
    endfunction

endpackage

// File: rtl/adc_freq_meas_zc_det.sv
// Rising mid-scale crossing detector with hysteresis.
// Registers the ADC sample once and emits a one-cycle crossing pulse.
module adc_freq_meas_zc_det
    import adc_freq_meas_pkg::*;
#(
    parameter int DATA_W = 14,
    parameter int HYST   = DEF_HYST
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] s1_o,
    output logic              xing_o
);

    localparam int MID = mid_code(DATA_W);
    localparam logic [DATA_W-1:0] HI_TH = DATA_W'(MID + HYST);
    localparam logic [DATA_W-1:0] LO_TH = DATA_W'(MID - HYST);

    logic [DATA_W-1:0] s1_q;
    logic              level_q;
    logic              level_d;
    logic              xing_q;

    // Schmitt trigger: set above the upper band edge, clear below the lower
    always_comb begin
        level_d = level_q;
        if (s1_q >= HI_TH) begin
            level_d = 1'b1;
        end else if (s1_q <= LO_TH) begin
            level_d = 1'b0;
        end
    end

    // Sample register, level register and registered 0->1 edge pulse
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q    <= '0;
            level_q <= 1'b0;
            xing_q  <= 1'b0;
        end else begin
            s1_q    <= data_i;
            level_q <= level_d;
            xing_q  <= level_d & ~level_q;
        end
    end

    assign s1_o   = s1_q;
    assign xing_o = xing_q;

endmodule

// File: rtl/adc_freq_meas.sv
// ADC frequency meter: averages the period over NPER rising crossings
// and reports peak-to-peak amplitude with a one-cycle valid strobe.
module adc_freq_meas
    import adc_freq_meas_pkg::*;
#(
    parameter int DATA_W    = 14,
    parameter int CNT_W     = 32,
    parameter int HYST      = DEF_HYST,
    parameter int LOG2_NPER = 4,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic              Clk,
    input  logic              Rst,
    output logic              AD_Clk,
    input  logic [DATA_W-1:0] AD_Data,
    input  logic              Start,
    output logic              Busy,
    output logic              Valid,
    output logic              Timeout,
    output logic [CNT_W-1:0]  Period_Cnt,
    output logic [DATA_W-1:0] Vpp
);

    localparam int K_W = LOG2_NPER + 1;
    localparam logic [K_W-1:0]   K_LAST = K_W'((1 << LOG2_NPER) - 1);
    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

    meas_state_e       state_q, state_d;
    logic [DATA_W-1:0] s1;
    logic              xing;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0]  idle_q, idle_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [DATA_W-1:0] min_q, min_d, min_nx;
    logic [DATA_W-1:0] max_q, max_d, max_nx;
    logic [CNT_W-1:0]  per_q, per_d;
    logic [DATA_W-1:0] vpp_q, vpp_d;
    logic              tout_q, tout_d;
    logic              idle_hit, last_xing;

    assign AD_Clk = Clk;

    adc_freq_meas_zc_det #(
        .DATA_W(DATA_W),
        .HYST  (HYST)
    ) u_zc (
        .clk_i (Clk),
        .rst_i (Rst),
        .data_i(AD_Data),
        .s1_o  (s1),
        .xing_o(xing)
    );

    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign min_nx    = (s1 < min_q) ? s1 : min_q;
    assign max_nx    = (s1 > max_q) ? s1 : max_q;
    assign idle_hit  = (idle_q == TO_CNT);
    assign last_xing = xing && (k_q == K_LAST);

    // State register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a crossing always takes priority over the idle timeout
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (Start) state_d = ST_ARM;
            ST_ARM: begin
                if (xing) state_d = ST_MEAS;
                else if (idle_hit) state_d = ST_DONE;
            end
            ST_MEAS: begin
                if (last_xing) state_d = ST_DONE;
                else if (!xing && idle_hit) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        Busy  = (state_q != ST_IDLE);
        Valid = (state_q == ST_DONE);
    end

    // Counters, min/max tracking and result capture on entry to DONE
    always_comb begin
        cnt_d  = cnt_q;
        idle_d = idle_q;
        k_d    = k_q;
        min_d  = min_q;
        max_d  = max_q;
        per_d  = per_q;
        vpp_d  = vpp_q;
        tout_d = tout_q;
        unique case (state_q)
            ST_IDLE: if (Start) idle_d = '0;
            ST_ARM: begin
                idle_d = idle_q + CNT_W'(1);
                if (xing) begin
                    cnt_d  = '0;
                    k_d    = '0;
                    min_d  = s1;
                    max_d  = s1;
                    idle_d = '0;
                end else if (idle_hit) begin
                    per_d  = '0;
                    vpp_d  = '0;
                    tout_d = 1'b1;
                end
            end
            ST_MEAS: begin
                cnt_d  = cnt_inc;
                idle_d = idle_q + CNT_W'(1);
                min_d  = min_nx;
                max_d  = max_nx;
                if (xing) begin
                    k_d    = k_q + K_W'(1);
                    idle_d = '0;
                    if (last_xing) begin
                        per_d  = cnt_inc >> LOG2_NPER;
                        vpp_d  = max_nx - min_nx;
                        tout_d = 1'b0;
                    end
                end else if (idle_hit) begin
                    per_d  = '0;
                    vpp_d  = '0;
                    tout_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_q  <= '0;
            idle_q <= '0;
            k_q    <= '0;
            min_q  <= '0;
            max_q  <= '0;
            per_q  <= '0;
            vpp_q  <= '0;
            tout_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idle_q <= idle_d;
            k_q    <= k_d;
            min_q  <= min_d;
            max_q  <= max_d;
            per_q  <= per_d;
            vpp_q  <= vpp_d;
            tout_q <= tout_d;
        end
    end

    assign Timeout    = tout_q;
    assign Period_Cnt = per_q;
    assign Vpp        = vpp_q;

endmodule
